// File: rtl/npu_pkg.sv
// Shared NPU launch constants.
// The decode stage uses the same indices when it raises en_npu.
package npu_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE  = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_WB_RES = 3'd3;
   localparam logic [2:0] ST_WB_CLR = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_ISSUE  = ST_ISSUE,
      S_RUN    = ST_RUN,
      S_WB_RES = ST_WB_RES,
      S_WB_CLR = ST_WB_CLR
   } npu_state_e;

   localparam int NPU_CMD_REG    = 13;
   localparam int NPU_RESULT_REG = 14;

   // A zero command word never launches anything.
   function automatic logic is_launch(input logic en, input logic nz);
      return en & nz;
   endfunction

   function automatic logic [4:0] reg_idx(input int r);
      return 5'(r);
   endfunction

endpackage

// File: rtl/npu_cmd_slot.sv
// One-entry command holding register.
// Pop and push in the same cycle replace the entry.
module npu_cmd_slot #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic [DATA_W-1:0] dout
);

   logic              full_q, full_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (pop) begin
         full_d = push;
         if (push) begin
            data_d = din;
         end
      end else if (push && !full_q) begin
         full_d = 1'b1;
         data_d = din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign dout = data_q;

endmodule

// File: rtl/npu_cmd_responder.sv
// NPU end of the x13 launch path: issue, run, write back the
// result to RESULT_REG, then clear CMD_REG so software can poll.
module npu_cmd_responder
   import npu_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CMD_REG    = NPU_CMD_REG,
   parameter int RESULT_REG = NPU_RESULT_REG,
   parameter int TIMEOUT    = 1024
) (
   input  logic              clk_50,
   input  logic              rst,
   input  logic              en_npu,
   input  logic [DATA_W-1:0] cmd_word,
   input  logic              npu_ready,
   output logic              npu_start,
   output logic [DATA_W-1:0] npu_cmd,
   input  logic              npu_done,
   input  logic [DATA_W-1:0] npu_result,
   output logic              wb_req,
   output logic [4:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic              wb_ack,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   npu_state_e        state_q, state_d;
   logic [DATA_W-1:0] active_q, active_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              overrun_q, overrun_d;
   logic              tmo_q, tmo_d;

   logic              launch;
   logic              pend_push;
   logic              pend_pop;
   logic              pend_full;
   logic [DATA_W-1:0] pend_data;

   assign launch = is_launch(en_npu, |cmd_word);

   npu_cmd_slot #(
      .DATA_W (DATA_W)
   ) u_pending (
      .clk  (clk_50),
      .rst  (rst),
      .push (pend_push),
      .pop  (pend_pop),
      .din  (cmd_word),
      .full (pend_full),
      .dout (pend_data)
   );

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
      tmo_d     = tmo_q;
      pend_push = 1'b0;
      pend_pop  = 1'b0;
      npu_start = 1'b0;
      wb_req    = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;

      unique case (state_q)
         S_IDLE: begin
            // A waiting command beats a new launch; the new one queues.
            if (pend_full) begin
               active_d  = pend_data;
               pend_pop  = 1'b1;
               pend_push = launch;
               state_d   = S_ISSUE;
            end else if (launch) begin
               active_d = cmd_word;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (npu_ready) begin
               npu_start = 1'b1;
               cnt_d     = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (npu_done) begin
               result_d = npu_result;
               state_d  = S_WB_RES;
            end else if (cnt_q == CNT_LAST) begin
               tmo_d    = 1'b1;
               result_d = '1;
               state_d  = S_WB_RES;
            end
         end
         S_WB_RES: begin
            wb_req  = 1'b1;
            wb_addr = reg_idx(RESULT_REG);
            wb_data = result_q;
            if (wb_ack) begin
               state_d = S_WB_CLR;
            end
         end
         S_WB_CLR: begin
            wb_req  = 1'b1;
            wb_addr = reg_idx(CMD_REG);
            wb_data = '0;
            if (wb_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_q != S_IDLE && launch) begin
         if (!pend_full) begin
            pend_push = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         active_q  <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
         tmo_q     <= tmo_d;
      end
   end

   assign npu_cmd     = active_q;
   assign busy        = (state_q != S_IDLE) || pend_full;
   assign overrun     = overrun_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_npu_cmd_responder.sv
// Bench for npu_cmd_responder: directed scenarios plus a
// randomized run against a queue-based model of the launch path.
module tb_npu_cmd_responder;

   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          clk_50 = 1'b0;
   logic          rst = 1'b0;
   logic          en_npu = 1'b0;
   logic [DW-1:0] cmd_word = '0;
   logic          npu_ready = 1'b0;
   logic          npu_start;
   logic [DW-1:0] npu_cmd;
   logic          npu_done = 1'b0;
   logic [DW-1:0] npu_result = '0;
   logic          wb_req;
   logic [4:0]    wb_addr;
   logic [DW-1:0] wb_data;
   logic          wb_ack = 1'b0;
   logic          busy;
   logic          overrun;
   logic          timeout_err;

   int total = 0;
   int bad = 0;

   npu_cmd_responder #(
      .DATA_W     (DW),
      .CMD_REG    (13),
      .RESULT_REG (14),
      .TIMEOUT    (TMO)
   ) dut (
      .clk_50      (clk_50),
      .rst         (rst),
      .en_npu      (en_npu),
      .cmd_word    (cmd_word),
      .npu_ready   (npu_ready),
      .npu_start   (npu_start),
      .npu_cmd     (npu_cmd),
      .npu_done    (npu_done),
      .npu_result  (npu_result),
      .wb_req      (wb_req),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_ack      (wb_ack),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   always #5 clk_50 = ~clk_50;

   task automatic nxt();
      @(posedge clk_50);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      en_npu     = 1'b0;
      cmd_word   = '0;
      npu_ready  = 1'b0;
      npu_done   = 1'b0;
      npu_result = '0;
      wb_ack     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      nxt();
      nxt();
      rst = 1'b1;
   endtask

   task automatic launch(input logic [DW-1:0] c);
      en_npu   = 1'b1;
      cmd_word = c;
      nxt();
      en_npu   = 1'b0;
      cmd_word = $urandom;
   endtask

   task automatic wait_start(input logic [DW-1:0] exp,
                             output int waited);
      int n;
      n = 0;
      npu_ready = 1'b1;
      settle();
      while (npu_start !== 1'b1 && n < 50) begin
         nxt();
         settle();
         n++;
      end
      waited = n;
      total++;
      if (npu_start !== 1'b1 || npu_cmd !== exp) begin
         bad++;
         $display("FAIL start: start=%b cmd=%h required start=1 cmd=%h",
                  npu_start, npu_cmd, exp);
      end
      nxt();
      settle();
      total++;
      if (npu_start !== 1'b0 || npu_cmd !== exp) begin
         bad++;
         $display("FAIL start_pulse: start=%b cmd=%h required start=0 cmd=%h",
                  npu_start, npu_cmd, exp);
      end
      npu_ready = 1'b0;
   endtask

   task automatic finish_cmd(input logic [DW-1:0] res, input int dly,
                             input int ack_dly);
      repeat (dly) nxt();
      npu_done   = 1'b1;
      npu_result = res;
      nxt();
      npu_done   = 1'b0;
      npu_result = $urandom;
      for (int i = 0; i <= ack_dly; i++) begin
         if (i > 0) nxt();
         wb_ack = (i == ack_dly);
         settle();
         total++;
         if (wb_req !== 1'b1 || wb_addr !== 5'd14 || wb_data !== res) begin
            bad++;
            $display("FAIL wb_res: req=%b addr=%0d data=%h required 1/14/%h",
                     wb_req, wb_addr, wb_data, res);
         end
      end
      nxt();
      settle();
      total++;
      if (wb_req !== 1'b1 || wb_addr !== 5'd13 || wb_data !== '0) begin
         bad++;
         $display("FAIL wb_clr: req=%b addr=%0d data=%h required 1/13/0",
                  wb_req, wb_addr, wb_data);
      end
      nxt();
      wb_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      en_npu     = 1'b1;
      cmd_word   = 32'h77;
      npu_ready  = 1'b1;
      npu_done   = 1'b1;
      wb_ack     = 1'b1;
      nxt();
      nxt();
      settle();
      total++;
      if ({npu_start, wb_req, busy, overrun, timeout_err,
           wb_addr, wb_data, npu_cmd} !== '0) begin
         bad++;
         $display("FAIL reset_hold: start=%b req=%b busy=%b ov=%b to=%b cmd=%h required all 0",
                  npu_start, wb_req, busy, overrun, timeout_err, npu_cmd);
      end
      idle_inputs();
      rst = 1'b1;
      nxt();
      settle();
      total++;
      if ({npu_start, wb_req, busy, overrun, timeout_err,
           wb_addr, wb_data, npu_cmd} !== '0) begin
         bad++;
         $display("FAIL reset_release: start=%b req=%b busy=%b cmd=%h required all 0",
                  npu_start, wb_req, busy, npu_cmd);
      end
   endtask

   task automatic test_basic();
      npu_ready = 1'b1;
      en_npu    = 1'b1;
      cmd_word  = 32'hA5;
      settle();
      total++;
      if (npu_start !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle_start: start=%b required 0", npu_start);
      end
      nxt();
      en_npu   = 1'b0;
      cmd_word = $urandom;
      settle();
      total++;
      if (npu_start !== 1'b1 || npu_cmd !== 32'hA5 || busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_start: start=%b cmd=%h busy=%b required 1/a5/1",
                  npu_start, npu_cmd, busy);
      end
      nxt();
      npu_ready = 1'b0;
      finish_cmd(32'h1234, 5, 0);
      settle();
      total++;
      if (busy !== 1'b0 || wb_req !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle: busy=%b req=%b required 0/0", busy, wb_req);
      end
      wb_ack = 1'b1;
      nxt();
      wb_ack = 1'b0;
      settle();
      total++;
      if (busy !== 1'b0 || wb_req !== 1'b0 || npu_start !== 1'b0) begin
         bad++;
         $display("FAIL stray_ack: busy=%b req=%b start=%b required 0",
                  busy, wb_req, npu_start);
      end
   endtask

   task automatic test_ready_stall();
      int starts;
      int waited;
      starts = 0;
      npu_ready = 1'b0;
      launch(32'hBEEF);
      repeat (10) begin
         settle();
         if (npu_start === 1'b1) starts++;
         nxt();
      end
      total++;
      if (starts != 0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL stall_no_start: starts=%0d busy=%b required 0/1",
                  starts, busy);
      end
      wait_start(32'hBEEF, waited);
      total++;
      if (waited != 0) begin
         bad++;
         $display("FAIL stall_latency: waited=%0d required 0", waited);
      end
      // done on the last allowed RUN cycle still counts as success
      finish_cmd(32'h5A5A_0001, TMO - 1, 1);
      settle();
      total++;
      if (timeout_err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_at_limit: to=%b busy=%b required 0/0",
                  timeout_err, busy);
      end
   endtask

   task automatic test_ack_stall();
      int waited;
      launch(32'h0000_0042);
      wait_start(32'h0000_0042, waited);
      finish_cmd(32'hCAFE_F00D, 2, 4);
      settle();
      total++;
      if (busy !== 1'b0 || wb_req !== 1'b0) begin
         bad++;
         $display("FAIL ack_stall_idle: busy=%b req=%b required 0/0",
                  busy, wb_req);
      end
   endtask

   task automatic test_overrun();
      int waited;
      launch(32'h1);
      wait_start(32'h1, waited);
      en_npu   = 1'b1;
      cmd_word = 32'h2;
      nxt();
      en_npu   = 1'b0;
      settle();
      total++;
      if (overrun !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL overrun_early: ov=%b busy=%b required 0/1",
                  overrun, busy);
      end
      en_npu   = 1'b1;
      cmd_word = 32'h3;
      nxt();
      en_npu   = 1'b0;
      cmd_word = $urandom;
      settle();
      total++;
      if (overrun !== 1'b1 || npu_cmd !== 32'h1) begin
         bad++;
         $display("FAIL overrun_set: ov=%b cmd=%h required 1/1",
                  overrun, npu_cmd);
      end
      finish_cmd(32'h1111, 1, 0);
      wait_start(32'h2, waited);
      total++;
      if (waited != 1) begin
         bad++;
         $display("FAIL pending_latency: waited=%0d required 1", waited);
      end
      finish_cmd(32'h2222, 2, 0);
      npu_ready = 1'b1;
      waited = 0;
      repeat (6) begin
         settle();
         if (npu_start === 1'b1 || busy === 1'b1) waited++;
         nxt();
      end
      npu_ready = 1'b0;
      settle();
      total++;
      if (waited != 0 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL dropped_cmd: extra=%0d ov=%b required 0/1",
                  waited, overrun);
      end
   endtask

   task automatic test_timeout();
      int n;
      int waited;
      launch(32'h7);
      wait_start(32'h7, waited);
      n = 1;
      while (wb_req !== 1'b1 && n < 100) begin
         nxt();
         settle();
         n++;
      end
      total++;
      if (n != TMO + 1 || timeout_err !== 1'b1 || wb_addr !== 5'd14 ||
          wb_data !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL timeout: run_cycles=%0d to=%b addr=%0d data=%h required %0d/1/14/ffffffff",
                  n - 1, timeout_err, wb_addr, wb_data, TMO);
      end
      wb_ack = 1'b1;
      nxt();
      settle();
      total++;
      if (wb_req !== 1'b1 || wb_addr !== 5'd13 || wb_data !== '0) begin
         bad++;
         $display("FAIL timeout_clr: req=%b addr=%0d data=%h required 1/13/0",
                  wb_req, wb_addr, wb_data);
      end
      nxt();
      wb_ack = 1'b0;
      settle();
      total++;
      if (busy !== 1'b0 || wb_req !== 1'b0 || timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_idle: busy=%b req=%b to=%b required 0/0/1",
                  busy, wb_req, timeout_err);
      end
   endtask

   task automatic test_reset_mid_run();
      int waited;
      launch(32'h99);
      wait_start(32'h99, waited);
      nxt();
      rst = 1'b0;
      nxt();
      rst = 1'b1;
      settle();
      total++;
      if ({npu_start, wb_req, busy, overrun, timeout_err,
           wb_addr, wb_data, npu_cmd} !== '0) begin
         bad++;
         $display("FAIL reset_run: start=%b req=%b busy=%b ov=%b to=%b cmd=%h required all 0",
                  npu_start, wb_req, busy, overrun, timeout_err, npu_cmd);
      end
      npu_done   = 1'b1;
      npu_result = 32'hDEAD;
      npu_ready  = 1'b1;
      nxt();
      npu_done   = 1'b0;
      waited = 0;
      repeat (4) begin
         settle();
         if (wb_req === 1'b1 || busy === 1'b1 || npu_start === 1'b1) waited++;
         nxt();
      end
      npu_ready = 1'b0;
      total++;
      if (waited != 0) begin
         bad++;
         $display("FAIL late_done: active_cycles=%0d required 0", waited);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] q[$];
      logic          ov;
      logic          running;
      logic          done_now;
      int            cd;
      int            wb_phase;
      logic [DW-1:0] wb_exp;
      logic [4:0]    exp_addr;
      logic [DW-1:0] exp_data;
      ov = 1'b0;
      running = 1'b0;
      cd = 0;
      wb_phase = 0;
      wb_exp = '0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         en_npu     = (cyc < 2500) && ($urandom_range(0, 5) == 0);
         cmd_word   = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom);
         npu_ready  = 1'($urandom_range(0, 1));
         wb_ack     = ($urandom_range(0, 2) != 0);
         npu_result = $urandom;
         npu_done   = 1'b0;
         done_now   = 1'b0;
         if (running) begin
            if (cd == 0) begin
               npu_done = 1'b1;
               done_now = 1'b1;
               running  = 1'b0;
               wb_exp   = npu_result;
            end else begin
               cd--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            npu_done = 1'b1;
         end
         settle();
         total++;
         if (busy !== (q.size() > 0) || overrun !== ov ||
             timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL rnd_status cyc=%0d: busy=%b ov=%b to=%b required %b/%b/0",
                     cyc, busy, overrun, timeout_err, q.size() > 0, ov);
         end
         if (npu_start === 1'b1) begin
            total++;
            if (q.size() == 0 || npu_cmd !== q[0] || !npu_ready || running) begin
               bad++;
               $display("FAIL rnd_start cyc=%0d: cmd=%h required %h",
                        cyc, npu_cmd, (q.size() > 0) ? q[0] : '0);
            end
            running = 1'b1;
            cd = $urandom_range(0, 6);
         end
         exp_addr = (wb_phase == 1) ? 5'd14 : 5'd13;
         exp_data = (wb_phase == 1) ? wb_exp : '0;
         total++;
         if (wb_req !== (wb_phase != 0) ||
             (wb_phase != 0 && (wb_addr !== exp_addr || wb_data !== exp_data))) begin
            bad++;
            $display("FAIL rnd_wb cyc=%0d: req=%b addr=%0d data=%h required %b/%0d/%h",
                     cyc, wb_req, wb_addr, wb_data, wb_phase != 0,
                     exp_addr, exp_data);
         end
         if (en_npu && cmd_word != '0) begin
            if (q.size() < 2) q.push_back(cmd_word);
            else ov = 1'b1;
         end
         if (wb_phase != 0 && wb_ack) begin
            if (wb_phase == 1) begin
               wb_phase = 2;
            end else begin
               wb_phase = 0;
               if (q.size() > 0) void'(q.pop_front());
            end
         end
         if (done_now) wb_phase = 1;
         nxt();
      end
      idle_inputs();
      settle();
      total++;
      if (busy !== 1'b0 || q.size() != 0) begin
         bad++;
         $display("FAIL rnd_drain: busy=%b left=%0d required 0/0",
                  busy, q.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      nxt();
      test_reset();
      test_basic();
      test_ready_stall();
      test_ack_stall();
      test_overrun();
      test_timeout();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
